// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
//   muldiv_state_e : sequencer FSM state encoding (6 states, 3 bits)
//   muldiv_op_e    : latched operation (none / multiply / divide / divide on memory operands)
//   cnt_width()    : latency counter width for a pair of cycle counts (minimum 1 bit)
package muldiv_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StInit   = 3'd1,
    StRun    = 3'd2,
    StCommit = 3'd3,
    StZexc   = 3'd4,
    StAbort  = 3'd5
  } muldiv_state_e;

  typedef enum logic [1:0] {
    OpNone = 2'd0,
    OpMult = 2'd1,
    OpDiv  = 2'd2,
    OpDivm = 2'd3
  } muldiv_op_e;

  localparam int unsigned MultCyclesDefault = 32;
  localparam int unsigned DivCyclesDefault  = 32;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter used to time the multiplier/divider latency.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (has priority over en_i)
//   en_i          : decrement by one; saturates at zero
//   load_val_i    : value to load
//   zero_o        : count is zero
module muldiv_cycle_counter #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the multiplier, divider and Hi/Lo registers for the multicycle CPU controller.
// A one-cycle request starts an operation: INIT strobes the unit, RUN waits the fixed latency,
// then COMMIT writes Hi/Lo. A divide with a zero divisor ends in ZEXC (exception pulse, no write);
// a flush during INIT/RUN ends in ABORT (stop strobe only). All outputs are Moore-decoded.
// Optional feature macro: MULDIV_DIVM_EN enables divide on memory operands (req_divm_i).
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   req_mult_i/req_div_i/req_divm_i : start requests (priority mult > div > divm)
//   flush_i                    : abort operation in flight
//   div_zero_i                 : divisor-zero flag from the divider
//   mult_init_o, mult_stop_o   : multiplier strobes
//   div_init_o, div_stop_o     : divider strobes
//   hilo_src_o                 : 1 = multiplier feeds Hi/Lo, 0 = divider
//   div_or_m_o                 : 1 = divider operands RegA/RegB, 0 = MDR/memory
//   hilo_write_o, busy_o, done_o, zero_exc_o : status/control
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_mult_i,
  input  logic req_div_i,
  input  logic req_divm_i,
  input  logic flush_i,
  input  logic div_zero_i,
  output logic mult_init_o,
  output logic mult_stop_o,
  output logic div_init_o,
  output logic div_stop_o,
  output logic hilo_src_o,
  output logic div_or_m_o,
  output logic hilo_write_o,
  output logic busy_o,
  output logic done_o,
  output logic zero_exc_o
);

  localparam int unsigned CntW = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  muldiv_state_e state_d, state_q;
  muldiv_op_e    op_d, op_q;
  logic          src_d, src_q;
  // High only during the first RUN cycle, when the divider's zero flag is meaningful.
  logic          first_d, first_q;

  logic            cnt_load, cnt_en, cnt_zero;
  logic [CntW-1:0] cnt_val;
  logic            is_div;

`ifdef MULDIV_DIVM_EN
  logic dom_d, dom_q;
`else
  logic unused_divm;
  assign unused_divm = req_divm_i;
`endif

  assign is_div  = (op_q == OpDiv) || (op_q == OpDivm);
  assign first_d = (state_q == StInit);

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_d    = src_q;
`ifdef MULDIV_DIVM_EN
    dom_d    = dom_q;
`endif
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;

    unique case (state_q)
      StIdle: begin
        // A flush in IDLE suppresses any same-cycle request.
        if (!flush_i) begin
          if (req_mult_i) begin
            op_d    = OpMult;
            src_d   = 1'b1;
`ifdef MULDIV_DIVM_EN
            dom_d   = 1'b1;
`endif
            state_d = StInit;
          end else if (req_div_i) begin
            op_d    = OpDiv;
            src_d   = 1'b0;
`ifdef MULDIV_DIVM_EN
            dom_d   = 1'b1;
`endif
            state_d = StInit;
`ifdef MULDIV_DIVM_EN
          end else if (req_divm_i) begin
            op_d    = OpDivm;
            src_d   = 1'b0;
            dom_d   = 1'b0;
            state_d = StInit;
`endif
          end
        end
      end
      StInit: begin
        cnt_load = 1'b1;
        cnt_val  = (op_q == OpMult) ? MultLoad : DivLoad;
        state_d  = flush_i ? StAbort : StRun;
      end
      StRun: begin
        cnt_en = 1'b1;
        if (flush_i) begin
          state_d = StAbort;
        end else if (is_div && first_q && div_zero_i) begin
          state_d = StZexc;
        end else if (cnt_zero) begin
          state_d = StCommit;
        end
      end
      StCommit, StZexc, StAbort: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= OpNone;
      src_q   <= 1'b0;
      first_q <= 1'b0;
`ifdef MULDIV_DIVM_EN
      dom_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      first_q <= first_d;
`ifdef MULDIV_DIVM_EN
      dom_q   <= dom_d;
`endif
    end
  end

  muldiv_cycle_counter #(
    .Width (CntW)
  ) u_cycle_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Moore output decode
  always_comb begin
    mult_init_o  = 1'b0;
    mult_stop_o  = 1'b0;
    div_init_o   = 1'b0;
    div_stop_o   = 1'b0;
    hilo_write_o = 1'b0;
    done_o       = 1'b0;
    zero_exc_o   = 1'b0;
    busy_o       = (state_q != StIdle);

    unique case (state_q)
      StInit: begin
        mult_init_o = (op_q == OpMult);
        div_init_o  = is_div;
      end
      StCommit: begin
        mult_stop_o  = (op_q == OpMult);
        div_stop_o   = is_div;
        hilo_write_o = 1'b1;
        done_o       = 1'b1;
      end
      StZexc: begin
        div_stop_o = 1'b1;
        zero_exc_o = 1'b1;
      end
      StAbort: begin
        mult_stop_o = (op_q == OpMult);
        div_stop_o  = is_div;
      end
      default: ;
    endcase
  end

  assign hilo_src_o = src_q;
`ifdef MULDIV_DIVM_EN
  assign div_or_m_o = dom_q;
`else
  assign div_or_m_o = 1'b1;
`endif

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequences the multiplier, divider and Hi/Lo registers of the multicycle CPU on behalf of the main controller. It accepts a one-cycle `mult`/`div`/`divm` request and drives the units' init/stop strobes. It counts each operation's fixed latency, steers the Hi/Lo source mux and the divider operand mux, and commits the result to Hi/Lo. It reports divide-by-zero as an exception pulse instead of writing Hi/Lo.

## Interface
- `MULT_CYCLES`, default 32: multiplier busy cycles after init, ≥1.
- `DIV_CYCLES`, default 32: divider busy cycles after init, ≥1.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-low.
- `req_mult`  in  1: start multiply (RegA×RegB), single-cycle pulse.
- `req_div`  in  1: start divide (RegA/RegB), single-cycle pulse.
- `req_divm`  in  1: start divide on memory operands (MDR/memory output), single-cycle pulse.
- `flush`  in  1: abort any operation in flight.
- `div_zero`  in  1: divisor-zero flag from the divider.
- `mult_init`, `mult_stop`  out  1: multiplier strobes.
- `div_init`, `div_stop`  out  1: divider strobes.
- `hilo_src`  out  1: 1 = multiplier results to Hi/Lo, 0 = divider results.
- `div_or_m`  out  1: 1 = divider operands RegA/RegB, 0 = MDR/memory.
- `hilo_write`  out  1: Hi/Lo load enable.
- `busy`  out  1: operation in flight.
- `done`  out  1: result committed this cycle.
- `zero_exc`  out  1: divide-by-zero exception pulse.

## Operation
- All outputs are Moore-decoded from registered state.
- Reset values:
  - state IDLE;
  - `hilo_src`=0;
  - `div_or_m`=1;
  - all other outputs 0.
- States: IDLE, INIT, RUN, COMMIT, ZEXC, ABORT.
- IDLE:
  - Requests are sampled only in IDLE.
  - Priority is `req_mult` > `req_div` > `req_divm`. Lower-priority simultaneous requests are dropped.
  - On a request: latch the op, load `hilo_src`/`div_or_m`, go to INIT.
- INIT: `busy`=1, plus `mult_init`=1 (mult) or `div_init`=1 (div/divm).
  - Load the counter with cycles−1.
  - Go to RUN.
- RUN: `busy`=1. The counter decrements each cycle.
  - Div ops only, first RUN cycle: if `div_zero`=1, go to ZEXC.
  - At counter=0: go to COMMIT.
- COMMIT: `busy`=1; the active unit's stop strobe =1; `hilo_write`=1; `done`=1. Go to IDLE.
- ZEXC: `busy`=1; `div_stop`=1; `zero_exc`=1; `hilo_write`=0. Go to IDLE.
- ABORT: `busy`=1; the active unit's stop strobe =1; no write, no `done`. Go to IDLE.
- `flush` in INIT or RUN goes to ABORT; it wins over a same-cycle `div_zero`.
- `flush` in COMMIT or ZEXC is ignored; the commit/exception completes.
- `flush` in IDLE: no effect, and it suppresses a same-cycle request.
- `hilo_src` and `div_or_m` hold from INIT through the terminal cycle. They keep their last values in IDLE.
- Requests arriving while busy are ignored; the controller must wait for `busy`=0.
- Reset mid-operation returns to IDLE immediately with reset output values. No stop strobe is issued; the units are reset by the same `rst`.

## Timing
- Request sampled at edge k:
  - INIT occupies cycle k+1;
  - RUN occupies k+2 .. k+1+N (N = MULT_CYCLES or DIV_CYCLES);
  - COMMIT occupies k+2+N.
- Hi/Lo capture at the end of the COMMIT cycle, so Hi/Lo are valid from k+3+N.
- `busy` is high for N+2 cycles.
- Divide-by-zero: ZEXC in cycle k+3, `zero_exc` high for exactly one cycle.
- Back-to-back: a new request may be issued in the first IDLE cycle after COMMIT.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)). Minimum 1 bit.

## Configuration
- `MULDIV_DIVM_EN` defined: `req_divm` is honoured as above and drives `div_or_m`=0.
- `MULDIV_DIVM_EN` undefined:
  - `req_divm` is ignored and treated as no request;
  - `div_or_m` is constant 1;
  - no state or logic is generated for the memory-operand path.

## Structure
- Package `muldiv_pkg`:
  - state encoding typedef (6 states, 3 bits);
  - op encoding typedef (NONE/MULT/DIV/DIVM);
  - default cycle-count constants.
- Sub-module `muldiv_cycle_counter`: loadable down-counter with `load`, `en`, `load_val` inputs and a `zero` flag, async active-low reset.
- The FSM and output decode stay in `muldiv_sequencer`.

## Test plan
- `req_mult` at cycle 0, MULT_CYCLES=32:
  - `mult_init` at cycle 1;
  - `mult_stop`, `hilo_write`, `done` at cycle 34;
  - `hilo_src`=1;
  - `busy` for cycles 1–34.
- `req_div` with `div_zero`=1:
  - `div_init` at 1;
  - `zero_exc` and `div_stop` at 3;
  - `hilo_write` never asserted;
  - IDLE at 4.
- `req_divm` with the macro defined: `div_or_m`=0 cycles 1–34 and `hilo_src`=0. With the macro undefined: no `busy`, no strobes.
- `req_mult`, `req_div` and `req_divm` in the same cycle: only the multiply runs. `req_div` during `busy`: ignored.
- `flush` at cycle 10 of a multiply:
  - ABORT at 11 with `mult_stop`=1, no `hilo_write`, no `done`;
  - IDLE at 12.
- `rst` low asynchronously mid-RUN: all outputs go to their reset values immediately (`div_or_m`=1). After release, `req_mult` produces the full nominal 34-cycle sequence.
